nn_out_buffer: RTL and testbench
================================

# nn_out_buffer

Output collection stage directly downstream of the two-column neural-network datapath. It captures the two leaky-ReLU output lanes (16-bit signed, each with its own valid, lane 2 lagging lane 1 by the systolic skew), deskews them into column pairs, and buffers the pairs in a FIFO. A host or the next layer's loader drains the pairs over a valid/ready handshake. Overflow and lane-desync conditions are flagged sticky rather than stalling the array, which has no backpressure.

## Interface
- `DEPTH`, 16: pair-FIFO entries; power of two, ≥ 2.
- `SKID`, 2: per-lane deskew entries; power of two, ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset; asynchronous, active-low.
- `flush` input 1: synchronous clear of all FIFOs and flags; has priority over every other input.
- `in_data_1` input 16: lane 1 sample, signed.
- `in_valid_1` input 1: lane 1 sample valid.
- `in_data_2` input 16: lane 2 sample, signed.
- `in_valid_2` input 1: lane 2 sample valid.
- `out_data_1` output 16: head pair, lane 1 value.
- `out_data_2` output 16: head pair, lane 2 value.
- `out_valid` output 1: a head pair is present.
- `out_ready` input 1: consumer accepts the head pair.
- `level` output $clog2(DEPTH)+1: number of pair-FIFO entries.
- `overflow` output 1: sticky; a formed pair was dropped.
- `desync` output 1: sticky; a lane sample was dropped because its skid was full.

## Operation
- Skid stage:
  - Each lane writes its sample into its own SKID-deep FIFO on a clock edge where its valid is high.
  - If that skid is full and is not popped on the same edge, the sample is dropped and `desync` sets.
- Pairing:
  - A pair forms when both skid heads are non-empty.
  - On that edge both heads pop and {lane2, lane1} is pushed into the pair FIFO. At most one pair forms per cycle.
- Pair FIFO:
  - A push when full with no pop on the same edge drops the pair and sets `overflow`. The skids still pop.
  - A push and a pop on the same edge when full are both accepted; `level` is unchanged.
- Pop: `out_valid && out_ready` on an edge removes the head. `out_data_*` always shows the head entry, and is 0 when empty.
- Pointers wrap modulo DEPTH or SKID. Full and empty are distinguished with an extra pointer bit.
- No arithmetic is applied. Data passes bit-exact, signed.
- `flush`, or `rst` asserted at any time including mid-burst:
  - empties all FIFOs and clears `overflow` and `desync`;
  - inputs sampled on the `flush` edge are discarded.
- Reset values: `out_valid`=0, `out_data_1`=`out_data_2`=0, `level`=0, `overflow`=0, `desync`=0. Statistics counters are 0.

## Timing
- Latency, measured from the cycle in which the later lane's valid is high (cycle t):
  - the sample is in its skid after edge t;
  - the pair is pushed at edge t+1;
  - `out_valid`=1 in cycle t+2.
- Both lanes valid in the same cycle is legal and gives the same t+2 latency.
- Throughput: one pair per cycle sustained when `out_ready` is held high.
- `out_ready` may be asserted without `out_valid`; that has no effect.
- `out_valid` does not depend combinationally on `out_ready`.
- `level` and the flags are registered and update on the same edge as the event that causes them.

## Configuration
- `NN_OUT_BUF_STATS_EN` defined:
  - adds output `pair_count` [31:0], counting accepted pushes and wrapping modulo 2^32;
  - adds output `drop_count` [15:0], counting dropped pairs plus dropped lane samples, saturating at 16'hFFFF;
  - both counters are cleared by `rst` and `flush`.
- Not defined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Lane 1 = 16'sd5 in cycle 3, lane 2 = -16'sd7 in cycle 4, `out_ready`=1 -> `out_valid`=1 in cycle 6 only, with `out_data_1`=5 and `out_data_2`=16'hFFF9.
- 20 skewed pairs (values 1..20, lane 2 = −lane 1) with `out_ready`=0, DEPTH=16 -> `level`=16, `overflow`=1, then draining gives pairs 1..16 in order. With stats enabled, `drop_count`=4 and `pair_count`=16.
- Full FIFO, then simultaneous push of pair 17 and pop -> `level` stays 16, `overflow` stays 0, and 17 is read last.
- Lane 1 valid 3 times with no lane 2 (SKID=2) -> `desync`=1. Subsequent lane 2 samples pair with the first two lane 1 samples.
- Assert `flush` with `level`=5 and both flags set -> next cycle `level`=0, `out_valid`=0, flags 0; a lane sample given on the `flush` cycle is absent.
- `rst` low mid-burst, asynchronously between edges -> all outputs are 0 immediately. After release, the next skewed pair appears 2 cycles after its later lane.

Source files
------------

// File: rtl/nn_out_buffer.sv
// nn_out_buffer
//   Output collection stage behind the two-column NN datapath. Each leaky-ReLU
//   lane lands in its own small skid FIFO; whenever both skid heads hold a
//   sample they are popped together and the column pair {lane2, lane1} is
//   pushed into the pair FIFO, which a consumer drains over valid/ready.
//   The array upstream cannot be stalled, so lost samples and lost pairs are
//   reported through sticky flags instead of backpressure.
//
//   Optional build macro: NN_OUT_BUF_STATS_EN adds pair_count (accepted pair
//   pushes, wrapping) and drop_count (dropped pairs + dropped lane samples,
//   saturating).
//
//   Handshake: the head pair is transferred on every rising edge where
//   out_valid && out_ready is high. out_valid is a pure function of stored
//   state and never looks at out_ready; out_ready without out_valid is ignored.
//
//   rst is asynchronous and active-low; flush is a synchronous clear that
//   overrides every other input on its edge.

module nn_out_buffer #(
    parameter int DEPTH = 16,
    parameter int SKID  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [15:0]              in_data_1,
    input  logic                     in_valid_1,
    input  logic [15:0]              in_data_2,
    input  logic                     in_valid_2,
    output logic [15:0]              out_data_1,
    output logic [15:0]              out_data_2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     desync
`ifdef NN_OUT_BUF_STATS_EN
    ,
    output logic [31:0]              pair_count,
    output logic [15:0]              drop_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(SKID);

    localparam logic [PW:0] P_ONE = (PW + 1)'(1);
    localparam logic [SW:0] S_ONE = (SW + 1)'(1);

    // Lane 1 skid storage and pointers (extra MSB separates full from empty)
    logic [15:0] s1_mem_q [SKID];
    logic [15:0] s1_mem_d [SKID];
    logic [SW:0] s1_wp_q, s1_wp_d;
    logic [SW:0] s1_rp_q, s1_rp_d;

    // Lane 2 skid storage and pointers
    logic [15:0] s2_mem_q [SKID];
    logic [15:0] s2_mem_d [SKID];
    logic [SW:0] s2_wp_q, s2_wp_d;
    logic [SW:0] s2_rp_q, s2_rp_d;

    // Pair FIFO storage and pointers, entry = {lane2, lane1}
    logic [31:0] p_mem_q [DEPTH];
    logic [31:0] p_mem_d [DEPTH];
    logic [PW:0] p_wp_q, p_wp_d;
    logic [PW:0] p_rp_q, p_rp_d;

    // Sticky status flags
    logic overflow_q, overflow_d;
    logic desync_q,   desync_d;

    // Derived status of the three FIFOs
    logic s1_empty, s1_full;
    logic s2_empty, s2_full;
    logic p_empty,  p_full;

    // Events of the current cycle
    logic pair_fire;
    logic s1_push, s1_drop;
    logic s2_push, s2_drop;
    logic p_push,  p_drop;
    logic p_pop;

    // FIFO occupancy decode and per-cycle event decisions
    always_comb begin
        s1_empty = (s1_wp_q == s1_rp_q);
        s1_full  = (s1_wp_q[SW] != s1_rp_q[SW]) &&
                   (s1_wp_q[SW-1:0] == s1_rp_q[SW-1:0]);
        s2_empty = (s2_wp_q == s2_rp_q);
        s2_full  = (s2_wp_q[SW] != s2_rp_q[SW]) &&
                   (s2_wp_q[SW-1:0] == s2_rp_q[SW-1:0]);
        p_empty  = (p_wp_q == p_rp_q);
        p_full   = (p_wp_q[PW] != p_rp_q[PW]) &&
                   (p_wp_q[PW-1:0] == p_rp_q[PW-1:0]);

        // A pair is formed only from samples already sitting in both skids,
        // which gives the one-cycle deskew stage before the pair FIFO.
        pair_fire = !s1_empty && !s2_empty;

        // A full skid still takes a sample when its head leaves this edge.
        s1_push = in_valid_1 && (!s1_full || pair_fire);
        s1_drop = in_valid_1 && s1_full && !pair_fire;
        s2_push = in_valid_2 && (!s2_full || pair_fire);
        s2_drop = in_valid_2 && s2_full && !pair_fire;

        p_pop  = !p_empty && out_ready;
        p_push = pair_fire && (!p_full || p_pop);
        p_drop = pair_fire && p_full && !p_pop;
    end

    // Lane 1 skid next state
    always_comb begin
        s1_mem_d = s1_mem_q;
        s1_wp_d  = s1_wp_q;
        s1_rp_d  = s1_rp_q;
        if (flush) begin
            s1_wp_d = '0;
            s1_rp_d = '0;
        end else begin
            if (s1_push) begin
                s1_mem_d[s1_wp_q[SW-1:0]] = in_data_1;
                s1_wp_d = s1_wp_q + S_ONE;
            end
            if (pair_fire) begin
                s1_rp_d = s1_rp_q + S_ONE;
            end
        end
    end

    // Lane 2 skid next state
    always_comb begin
        s2_mem_d = s2_mem_q;
        s2_wp_d  = s2_wp_q;
        s2_rp_d  = s2_rp_q;
        if (flush) begin
            s2_wp_d = '0;
            s2_rp_d = '0;
        end else begin
            if (s2_push) begin
                s2_mem_d[s2_wp_q[SW-1:0]] = in_data_2;
                s2_wp_d = s2_wp_q + S_ONE;
            end
            if (pair_fire) begin
                s2_rp_d = s2_rp_q + S_ONE;
            end
        end
    end

    // Pair FIFO next state: write the deskewed pair, advance on consumer pop
    always_comb begin
        p_mem_d = p_mem_q;
        p_wp_d  = p_wp_q;
        p_rp_d  = p_rp_q;
        if (flush) begin
            p_wp_d = '0;
            p_rp_d = '0;
        end else begin
            if (p_push) begin
                p_mem_d[p_wp_q[PW-1:0]] = {s2_mem_q[s2_rp_q[SW-1:0]],
                                           s1_mem_q[s1_rp_q[SW-1:0]]};
                p_wp_d = p_wp_q + P_ONE;
            end
            if (p_pop) begin
                p_rp_d = p_rp_q + P_ONE;
            end
        end
    end

    // Sticky flags: set on a drop, cleared only by flush or reset
    always_comb begin
        overflow_d = overflow_q;
        desync_d   = desync_q;
        if (flush) begin
            overflow_d = 1'b0;
            desync_d   = 1'b0;
        end else begin
            if (p_drop) begin
                overflow_d = 1'b1;
            end
            if (s1_drop || s2_drop) begin
                desync_d = 1'b1;
            end
        end
    end

    // State registers for skids, pair FIFO and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_mem_q   <= '{default: '0};
            s1_wp_q    <= '0;
            s1_rp_q    <= '0;
            s2_mem_q   <= '{default: '0};
            s2_wp_q    <= '0;
            s2_rp_q    <= '0;
            p_mem_q    <= '{default: '0};
            p_wp_q     <= '0;
            p_rp_q     <= '0;
            overflow_q <= 1'b0;
            desync_q   <= 1'b0;
        end else begin
            s1_mem_q   <= s1_mem_d;
            s1_wp_q    <= s1_wp_d;
            s1_rp_q    <= s1_rp_d;
            s2_mem_q   <= s2_mem_d;
            s2_wp_q    <= s2_wp_d;
            s2_rp_q    <= s2_rp_d;
            p_mem_q    <= p_mem_d;
            p_wp_q     <= p_wp_d;
            p_rp_q     <= p_rp_d;
            overflow_q <= overflow_d;
            desync_q   <= desync_d;
        end
    end

    // Output view of the pair FIFO head; zero while empty
    always_comb begin
        out_valid  = !p_empty;
        out_data_1 = '0;
        out_data_2 = '0;
        if (!p_empty) begin
            out_data_1 = p_mem_q[p_rp_q[PW-1:0]][15:0];
            out_data_2 = p_mem_q[p_rp_q[PW-1:0]][31:16];
        end
        level    = p_wp_q - p_rp_q;
        overflow = overflow_q;
        desync   = desync_q;
    end

`ifdef NN_OUT_BUF_STATS_EN
    logic [31:0] pair_cnt_q, pair_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    // Statistics next state: wrapping pair count, saturating drop count
    always_comb begin
        drop_inc   = {1'b0, p_drop} + {1'b0, s1_drop} + {1'b0, s2_drop};
        drop_sum   = {1'b0, drop_cnt_q} + {15'b0, drop_inc};
        pair_cnt_d = pair_cnt_q + {31'b0, p_push};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (flush) begin
            pair_cnt_d = '0;
            drop_cnt_d = '0;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pair_cnt_q <= pair_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pair_count = pair_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_nn_out_buffer.sv
// Bench for nn_out_buffer. A queue-level reference model advances on every
// clock edge from the spec rules (skids as bounded queues, pair FIFO as the
// expected-response queue); a monitor on the falling edge compares the DUT
// head, level and flags against it. Directed scenarios follow the test plan,
// then a randomized phase with skew, ready throttling and occasional flush.
module tb_nn_out_buffer;
  localparam int DEPTH = 16;
  localparam int SKID  = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] d1, d2;
  logic        v1, v2;
  logic        rdy;
  logic [15:0] out_data_1, out_data_2;
  logic        out_valid;
  logic [$clog2(DEPTH):0] level;
  logic        overflow, desync;
`ifdef NN_OUT_BUF_STATS_EN
  logic [31:0] pair_count;
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic [15:0] l1_q[$];
  logic [15:0] l2_q[$];
  logic        m_ovf, m_des;
  logic [31:0] m_pairs;
  int          m_drops;
  bit          m_fire, m_pop;
  logic [15:0] m_h1, m_h2;

  // random-phase scratch
  logic        nv1, nv2, nrdy, nfl, pv;
  logic [15:0] nd1, nd2;

  nn_out_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_data_1  (d1),
    .in_valid_1 (v1),
    .in_data_2  (d2),
    .in_valid_2 (v2),
    .out_data_1 (out_data_1),
    .out_data_2 (out_data_2),
    .out_valid  (out_valid),
    .out_ready  (rdy),
    .level      (level),
    .overflow   (overflow),
    .desync     (desync)
`ifdef NN_OUT_BUF_STATS_EN
    ,
    .pair_count (pair_count),
    .drop_count (drop_count)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    l1_q.delete();
    l2_q.delete();
    m_ovf   = 1'b0;
    m_des   = 1'b0;
    m_pairs = '0;
    m_drops = 0;
  endtask

  task automatic model_drop();
    if (m_drops < 65535) m_drops++;
  endtask

  // reference model: one step per edge using the values sampled on that edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_clear();
    end else if (flush) begin
      model_clear();
    end else begin
      m_fire = (l1_q.size() > 0) && (l2_q.size() > 0);
      m_pop  = rdy && (exp_q.size() > 0);
      m_h1 = '0;
      m_h2 = '0;
      if (m_fire) begin
        m_h1 = l1_q.pop_front();
        m_h2 = l2_q.pop_front();
      end
      if (v1) begin
        if (l1_q.size() < SKID) l1_q.push_back(d1);
        else begin m_des = 1'b1; model_drop(); end
      end
      if (v2) begin
        if (l2_q.size() < SKID) l2_q.push_back(d2);
        else begin m_des = 1'b1; model_drop(); end
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_fire) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back({m_h2, m_h1});
          m_pairs = m_pairs + 32'd1;
        end else begin
          m_ovf = 1'b1;
          model_drop();
        end
      end
    end
  end

  // monitor: compare DUT output against the model away from the active edge
  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("level", 32'(level), 32'(exp_q.size()));
    if (exp_q.size() != 0) begin
      check("head_lane1", 32'(out_data_1), 32'(exp_q[0][15:0]));
      check("head_lane2", 32'(out_data_2), 32'(exp_q[0][31:16]));
    end else begin
      check("empty_lane1", 32'(out_data_1), 32'd0);
      check("empty_lane2", 32'(out_data_2), 32'd0);
    end
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("desync", 32'(desync), 32'(m_des));
`ifdef NN_OUT_BUF_STATS_EN
    check("pair_count", pair_count, m_pairs);
    check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
  end

  // driver: hold inputs for one full cycle, return just after the edge
  task automatic drive(input logic iv1, input logic [15:0] id1,
                       input logic iv2, input logic [15:0] id2,
                       input logic irdy, input logic ifl);
    v1 = iv1; d1 = id1; v2 = iv2; d2 = id2; rdy = irdy; flush = ifl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic irdy);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 16'h0, irdy, 1'b0);
  endtask

  // skewed burst: lane 1 = base+i, lane 2 = -(base+i) one cycle later
  task automatic skewed_burst(input int n, input int base, input logic irdy);
    for (int i = 0; i <= n; i++)
      drive(i < n, 16'(base + i), i > 0, 16'(-(base + i - 1)), irdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0; rdy = 1'b0;
    pv = 1'b0;
    #2 rst = 1'b0;
    #20 rst = 1'b1;
    @(posedge clk); #1;
    idle(2, 1'b0);

    // single skewed pair, consumer ready: valid exactly two cycles after lane 2
    drive(1'b1, 16'sd5, 1'b0, 16'h0, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 1'b1, -16'sd7, 1'b1, 1'b0);
    idle(4, 1'b1);

    // 20 skewed pairs into a 16-deep FIFO with no consumer, then drain
    skewed_burst(20, 1, 1'b0);
    idle(3, 1'b0);
    idle(22, 1'b1);

    // fill exactly, then push pair 17 on the same edge as a pop
    skewed_burst(16, 1, 1'b0);
    idle(2, 1'b0);
    drive(1'b1, 16'd17, 1'b1, -16'sd17, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(20, 1'b1);

    // lane 1 three times with no lane 2 overruns its skid
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(100 + i), 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b0, 16'h0, 1'b1, 16'(200 + i), 1'b0, 1'b0);
    idle(3, 1'b0);

    // overflow on top, drain down, then flush with samples on the flush edge
    skewed_burst(20, 300, 1'b0);
    idle(2, 1'b0);
    idle(11, 1'b1);
    drive(1'b1, 16'h5555, 1'b1, 16'h6666, 1'b0, 1'b1);
    idle(4, 1'b1);

    // asynchronous reset in the middle of a burst
    skewed_burst(5, 400, 1'b0);
    drive(1'b1, 16'd500, 1'b1, 16'd501, 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_level", 32'(level), 32'd0);
    check("async_lane1", 32'(out_data_1), 32'd0);
    check("async_lane2", 32'(out_data_2), 32'd0);
    check("async_flags", 32'({overflow, desync}), 32'd0);
    v1 = 1'b0; v2 = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 16'h1234, 1'b0, 16'h0, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 1'b1, 16'hABCD, 1'b1, 1'b0);
    idle(4, 1'b1);

    // randomized traffic: mostly one-cycle skew, ready phases, rare flush
    for (int n = 0; n < 2000; n++) begin
      nv1 = ($urandom_range(0, 2) != 0);
      nd1 = 16'($urandom);
      nd2 = 16'($urandom);
      nv2 = pv;
      if ($urandom_range(0, 49) == 0) nv2 = !nv2;
      if (((n / 200) % 2) == 1) nrdy = ($urandom_range(0, 3) == 0);
      else nrdy = ($urandom_range(0, 3) != 0);
      nfl = ($urandom_range(0, 399) == 0);
      drive(nv1, nd1, nv2, nd2, nrdy, nfl);
      pv = nv1;
    end
    idle(24, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
